// File: rtl/wb_fabric_cfg_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_fabric_cfg_ctrl_if
//
// Bundles the upstream Wishbone slave port and the downstream fabric master
// port of wb_fabric_cfg_ctrl.
//
// Signals:
//   wbs_stb_i, wbs_cyc_i, wbs_we_i   upstream Wishbone control
//   wbs_sel_i[3:0]                   upstream byte select
//   wbs_dat_i[31:0]                  upstream write data
//   wbs_adr_i[31:0]                  upstream address
//   wbs_ack_o                        upstream ack
//   wbs_dat_o[31:0]                  upstream read data
//   fab_stb_o, fab_cyc_o, fab_we_o   fabric control
//   fab_sel_o[3:0]                   fabric byte select
//   fab_dat_o[31:0]                  fabric write data
//   fab_adr_o[31:0]                  fabric address
//   fab_ack_i                        fabric ack (already muxed by configuration)
//   fab_dat_i[31:0]                  fabric read data (already muxed)
//
// Modports:
//   slave  - the controller's view (takes upstream requests, drives fabric)
//   master - the environment's view (issues upstream requests, answers fabric)
// -----------------------------------------------------------------------------
interface wb_fabric_cfg_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    logic        fab_stb_o;
    logic        fab_cyc_o;
    logic        fab_we_o;
    logic [3:0]  fab_sel_o;
    logic [31:0] fab_dat_o;
    logic [31:0] fab_adr_o;
    logic        fab_ack_i;
    logic [31:0] fab_dat_i;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o,
        output fab_stb_o, fab_cyc_o, fab_we_o, fab_sel_o, fab_dat_o, fab_adr_o,
        input  fab_ack_i, fab_dat_i
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o,
        input  fab_stb_o, fab_cyc_o, fab_we_o, fab_sel_o, fab_dat_o, fab_adr_o,
        output fab_ack_i, fab_dat_i
    );
endinterface

// File: rtl/wb_fabric_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// wb_fabric_cfg_ctrl
//
// Wishbone front-end for the 2x2 horizontal-line routing fabric. Owns the
// fabric configuration register, serves CFG (CFG_ADDR) and STATUS
// (CFG_ADDR+4) locally, and forwards every other access to the fabric, one
// transaction at a time. configuration only changes on a local access, so it
// is stable for the whole life of a forwarded transaction.
//
// Optional feature macro: FAB_TIMEOUT_EN
//   defined   - forwarded transactions are bounded by a TIMEOUT-cycle timer;
//               a timeout returns 32'hDEAD_BEEF, sets a sticky flag and bumps
//               a saturating 8-bit count, both visible in STATUS.
//   undefined - no timer; FWD waits for fab_ack_i or a master abort, STATUS
//               reads 0 and writes to it are acked without effect.
//
// Parameters:
//   CFG_ADDR  address of CFG; STATUS is at CFG_ADDR+4
//   TIMEOUT   forwarded-transaction timeout in cycles (1..255)
//
// Ports:
//   wb_clk_i       clock
//   wb_rst_i       asynchronous active-high reset
//   bus            wb_fabric_cfg_ctrl_if.slave (upstream + fabric signals)
//   configuration  fabric configuration register (registered)
// -----------------------------------------------------------------------------
module wb_fabric_cfg_ctrl #(
    parameter logic [31:0] CFG_ADDR = 32'h3000_FF00,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    wb_fabric_cfg_ctrl_if.slave        bus,
    output logic [3:0]                 configuration
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam logic [31:0] STATUS_ADDR = CFG_ADDR + 32'd4;
    localparam logic [31:0] TMO_DATA    = 32'hDEAD_BEEF;

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] rdat_q, rdat_d;
    logic        fab_req_q, fab_req_d;  // drives both fab_stb_o and fab_cyc_o
    logic        fab_we_q, fab_we_d;
    logic [3:0]  fab_sel_q, fab_sel_d;
    logic [31:0] fab_dat_q, fab_dat_d;
    logic [31:0] fab_adr_q, fab_adr_d;
    logic [3:0]  cfg_q, cfg_d;

`ifdef FAB_TIMEOUT_EN
    // The timer holds the number of FWD edges already survived, so the
    // timeout fires on the edge where it reads TIMEOUT-1 (edge TIMEOUT).
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [7:0]  timer_q, timer_d;
    logic        tmo_flag_q, tmo_flag_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
`endif

    logic        req;
    logic        hit_cfg;
    logic        hit_status;
    logic [31:0] status_word;

    assign req        = bus.wbs_stb_i & bus.wbs_cyc_i;
    assign hit_cfg    = (bus.wbs_adr_i == CFG_ADDR);
    assign hit_status = (bus.wbs_adr_i == STATUS_ADDR);

`ifdef FAB_TIMEOUT_EN
    assign status_word = {16'b0, tmo_cnt_q, 7'b0, tmo_flag_q};
`else
    assign status_word = 32'b0;
`endif

    // Next-state and output logic.
    // NOTE: every _d is given its hold value before the case statement, so no
    // path through the block leaves a variable unassigned and no latch is
    // inferred.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        rdat_d    = rdat_q;
        fab_req_d = fab_req_q;
        fab_we_d  = fab_we_q;
        fab_sel_d = fab_sel_q;
        fab_dat_d = fab_dat_q;
        fab_adr_d = fab_adr_q;
        cfg_d     = cfg_q;
`ifdef FAB_TIMEOUT_EN
        timer_d    = timer_q;
        tmo_flag_d = tmo_flag_q;
        tmo_cnt_d  = tmo_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit_cfg || hit_status) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        if (bus.wbs_we_i) begin
                            rdat_d = 32'b0;
                            if (hit_cfg && bus.wbs_sel_i[0]) begin
                                cfg_d = bus.wbs_dat_i[3:0];
                            end
`ifdef FAB_TIMEOUT_EN
                            if (hit_status) begin
                                tmo_flag_d = 1'b0;
                                tmo_cnt_d  = 8'd0;
                            end
`endif
                        end else begin
                            rdat_d = hit_cfg ? {28'b0, cfg_q} : status_word;
                        end
                    end else begin
                        state_d   = FWD;
                        fab_req_d = 1'b1;
                        fab_we_d  = bus.wbs_we_i;
                        fab_sel_d = bus.wbs_sel_i;
                        fab_dat_d = bus.wbs_dat_i;
                        fab_adr_d = bus.wbs_adr_i;
`ifdef FAB_TIMEOUT_EN
                        timer_d   = 8'd0;
`endif
                    end
                end
            end

            FWD: begin
                // Abort outranks ack: a master that has dropped cyc must never
                // see an ack for the abandoned cycle.
                if (!bus.wbs_cyc_i) begin
                    state_d   = IDLE;
                    fab_req_d = 1'b0;
                end else if (bus.fab_ack_i) begin
                    state_d   = ACK;
                    ack_d     = 1'b1;
                    fab_req_d = 1'b0;
                    rdat_d    = fab_we_q ? 32'b0 : bus.fab_dat_i;
                end
`ifdef FAB_TIMEOUT_EN
                else if (timer_q == TIMER_LAST) begin
                    state_d    = ACK;
                    ack_d      = 1'b1;
                    fab_req_d  = 1'b0;
                    rdat_d     = TMO_DATA;
                    tmo_flag_d = 1'b1;
                    if (tmo_cnt_q != 8'hFF) begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
`endif
            end

            // One-cycle ack; the request is deliberately not looked at here
            // so a strobe the master has not yet dropped is not re-served.
            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            rdat_q     <= 32'b0;
            fab_req_q  <= 1'b0;
            fab_we_q   <= 1'b0;
            fab_sel_q  <= 4'b0;
            fab_dat_q  <= 32'b0;
            fab_adr_q  <= 32'b0;
            cfg_q      <= 4'b0;
`ifdef FAB_TIMEOUT_EN
            timer_q    <= 8'd0;
            tmo_flag_q <= 1'b0;
            tmo_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            rdat_q     <= rdat_d;
            fab_req_q  <= fab_req_d;
            fab_we_q   <= fab_we_d;
            fab_sel_q  <= fab_sel_d;
            fab_dat_q  <= fab_dat_d;
            fab_adr_q  <= fab_adr_d;
            cfg_q      <= cfg_d;
`ifdef FAB_TIMEOUT_EN
            timer_q    <= timer_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = rdat_q;
    assign bus.fab_stb_o = fab_req_q;
    assign bus.fab_cyc_o = fab_req_q;
    assign bus.fab_we_o  = fab_we_q;
    assign bus.fab_sel_o = fab_sel_q;
    assign bus.fab_dat_o = fab_dat_q;
    assign bus.fab_adr_o = fab_adr_q;
    assign configuration = cfg_q;
endmodule

// File: tb/tb_wb_fabric_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_fabric_cfg_ctrl
//
// Self-checking bench for wb_fabric_cfg_ctrl (CFG_ADDR default, TIMEOUT = 8).
// Works for both builds: expectations follow FAB_TIMEOUT_EN.
// The reference model keeps configuration, the timeout flag and count as
// plain variables and derives each transaction's ack cycle, returned data and
// fabric-busy length from the transaction rules. All inputs are driven and
// all outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_fabric_cfg_ctrl;
    localparam logic [31:0] CFG_ADDR    = 32'h3000_FF00;
    localparam logic [31:0] STATUS_ADDR = CFG_ADDR + 32'd4;
    localparam int          TIMEOUT     = 8;
`ifdef FAB_TIMEOUT_EN
    localparam bit          TMO_EN      = 1'b1;
`else
    localparam bit          TMO_EN      = 1'b0;
`endif

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i;
    logic [3:0] configuration;

    wb_fabric_cfg_ctrl_if bus ();

    wb_fabric_cfg_ctrl #(
        .CFG_ADDR (CFG_ADDR),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .bus           (bus),
        .configuration (configuration)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [3:0] m_cfg  = 4'd0;
    logic       m_flag = 1'b0;
    logic [7:0] m_cnt  = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return TMO_EN ? {16'b0, m_cnt, 7'b0, m_flag} : 32'b0;
    endfunction

    task automatic drive_idle();
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_dat_i = 32'h0;
        bus.wbs_adr_i = 32'h0;
        bus.fab_ack_i = 1'b0;
    endtask

    task automatic drive_req(input logic [31:0] adr, input logic we,
                             input logic [31:0] dat, input logic [3:0] sel);
        bus.wbs_adr_i = adr;
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
    endtask

    // One complete transaction. Called and returns at a falling edge.
    // ack_edge: edge (counted from the request edge 0) at which the fabric
    // acks; 0 means the fabric never answers.
    task automatic run_txn(input string tag, input logic [31:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int ack_edge, input logic [31:0] fdat);
        bit          local_acc;
        bit          timed_out = 1'b0;
        bit          hold_ok   = 1'b1;
        int          k = 0;
        int          e;
        int          ack_first = 0;
        int          ack_cnt   = 0;
        int          stb_cnt   = 0;
        logic [31:0] exp_dat;
        logic [31:0] got_dat   = 32'h0;

        local_acc = (adr == CFG_ADDR) || (adr == STATUS_ADDR);
        if (local_acc) begin
            e = 1;
            if (we) begin
                exp_dat = 32'h0;
                if (adr == CFG_ADDR && sel[0]) m_cfg = dat[3:0];
                if (adr == STATUS_ADDR) begin
                    m_flag = 1'b0;
                    m_cnt  = 8'd0;
                end
            end else begin
                exp_dat = (adr == CFG_ADDR) ? {28'b0, m_cfg} : m_status();
            end
        end else begin
            if (ack_edge >= 1 && (!TMO_EN || ack_edge <= TIMEOUT)) begin
                k = ack_edge;
            end else begin
                k = TIMEOUT;
                timed_out = 1'b1;
            end
            e = k + 1;
            if (timed_out) begin
                exp_dat = 32'hDEAD_BEEF;
                m_flag  = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end else begin
                exp_dat = we ? 32'h0 : fdat;
            end
        end

        bus.fab_dat_i = fdat;
        bus.fab_ack_i = 1'b0;
        drive_req(adr, we, dat, sel);
        for (int c = 1; c <= e + 2; c++) begin
            @(negedge wb_clk_i);
            if (bus.wbs_ack_o === 1'b1) begin
                ack_cnt++;
                if (ack_first == 0) begin
                    ack_first = c;
                    got_dat   = bus.wbs_dat_o;
                end
                bus.wbs_stb_i = 1'b0;
                bus.wbs_cyc_i = 1'b0;
            end
            if (bus.fab_stb_o === 1'b1) begin
                stb_cnt++;
                if (bus.fab_cyc_o !== 1'b1 || bus.fab_adr_o !== adr || bus.fab_we_o !== we ||
                    bus.fab_sel_o !== sel || bus.fab_dat_o !== dat)
                    hold_ok = 1'b0;
            end else if (bus.fab_cyc_o !== 1'b0) begin
                hold_ok = 1'b0;
            end
            bus.fab_ack_i = (!local_acc && c == ack_edge);
        end
        drive_idle();

        check({tag, "_ack_cycle"}, ack_first, e);
        check({tag, "_ack_count"}, ack_cnt, 1);
        check({tag, "_rdata"}, got_dat, exp_dat);
        check({tag, "_config"}, {28'b0, configuration}, {28'b0, m_cfg});
        if (local_acc) begin
            check({tag, "_fab_quiet"}, stb_cnt, 0);
        end else begin
            check({tag, "_fab_cycles"}, stb_cnt, k);
            check({tag, "_fab_hold"}, {31'b0, hold_ok}, 32'd1);
        end
    endtask

    // Forward then drop cyc in cycle 2 of FWD; returns in cycle 3 so the next
    // request is presented straight away.
    task automatic run_abort(input string tag, input logic [31:0] adr, input bit ack_too);
        int ack_cnt = 0;
        bus.fab_dat_i = $urandom;
        drive_req(adr, 1'b0, 32'h0, 4'hF);
        for (int c = 1; c <= 3; c++) begin
            @(negedge wb_clk_i);
            if (bus.wbs_ack_o === 1'b1) ack_cnt++;
            if (c == 2) begin
                check({tag, "_fab_stb_busy"}, {31'b0, bus.fab_stb_o}, 32'd1);
                bus.wbs_stb_i = 1'b0;
                bus.wbs_cyc_i = 1'b0;
                bus.fab_ack_i = ack_too;
            end else begin
                bus.fab_ack_i = 1'b0;
            end
        end
        check({tag, "_fab_stb_low"}, {31'b0, bus.fab_stb_o}, 32'd0);
        check({tag, "_fab_cyc_low"}, {31'b0, bus.fab_cyc_o}, 32'd0);
        check({tag, "_no_ack"}, ack_cnt, 0);
        drive_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, {31'b0, bus.wbs_ack_o}, 32'd0);
        check({tag, "_dat"}, bus.wbs_dat_o, 32'd0);
        check({tag, "_fab_stb"}, {31'b0, bus.fab_stb_o}, 32'd0);
        check({tag, "_fab_cyc"}, {31'b0, bus.fab_cyc_o}, 32'd0);
        check({tag, "_fab_we"}, {31'b0, bus.fab_we_o}, 32'd0);
        check({tag, "_fab_sel"}, {28'b0, bus.fab_sel_o}, 32'd0);
        check({tag, "_fab_dat"}, bus.fab_dat_o, 32'd0);
        check({tag, "_fab_adr"}, bus.fab_adr_o, 32'd0);
        check({tag, "_config"}, {28'b0, configuration}, 32'd0);
    endtask

    initial begin
        logic [31:0] adr;
        int          kind;

        drive_idle();
        bus.fab_dat_i = 32'h0;
        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        check_all_zero("reset");
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check_all_zero("post_reset");

        // Configuration write / read-back.
        run_txn("wr_cfg_2", CFG_ADDR, 1'b1, 32'h0000_0002, 4'hF, 0, 32'h0);
        run_txn("rd_cfg_2", CFG_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_txn("wr_cfg_nosel", CFG_ADDR, 1'b1, 32'h0000_0003, 4'hE, 0, 32'h0);
        run_txn("rd_cfg_nosel", CFG_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);

        // Forwarded read, fabric acks at edge 3.
        run_txn("fwd_rd", 32'h3000_0010, 1'b0, 32'h0, 4'hF, 3, 32'hA5A5_1234);
        run_txn("fwd_wr", 32'h3000_0020, 1'b1, 32'h1234_5678, 4'h3, 1, 32'hFFFF_FFFF);

`ifdef FAB_TIMEOUT_EN
        run_txn("tmo_1", 32'h3000_0030, 1'b0, 32'h0, 4'hF, 0, 32'h1111_1111);
        run_txn("status_1", STATUS_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_txn("tmo_2", 32'h3000_0034, 1'b1, 32'h5555_5555, 4'hF, 0, 32'h0);
        run_txn("status_2", STATUS_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_txn("status_clr", STATUS_ADDR, 1'b1, 32'h0, 4'hF, 0, 32'h0);
        run_txn("status_0", STATUS_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_txn("ack_at_tmo", 32'h3000_0040, 1'b0, 32'h0, 4'hF, TIMEOUT, 32'hC0FF_EE00);
        run_txn("status_after_race", STATUS_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        for (int i = 0; i < 256; i++) begin
            run_txn("tmo_sat", 32'h3000_0100, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        end
        run_txn("status_sat", STATUS_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_txn("status_clr2", STATUS_ADDR, 1'b1, 32'h0, 4'hF, 0, 32'h0);
`else
        run_txn("status_0", STATUS_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_txn("status_wr", STATUS_ADDR, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0);
        run_txn("status_0b", STATUS_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        begin : hang
            int stb_cnt = 0;
            int ack_cnt = 0;
            drive_req(32'h3000_0050, 1'b0, 32'h0, 4'hF);
            for (int c = 1; c <= 1000; c++) begin
                @(negedge wb_clk_i);
                if (bus.fab_stb_o === 1'b1) stb_cnt++;
                if (bus.wbs_ack_o === 1'b1) ack_cnt++;
            end
            check("hang_fab_busy", stb_cnt, 1000);
            check("hang_no_ack", ack_cnt, 0);
            drive_idle();
            @(negedge wb_clk_i);
            @(negedge wb_clk_i);
            check("hang_abort_stb", {31'b0, bus.fab_stb_o}, 32'd0);
        end
`endif

        // Master aborts, with and without a coincident fabric ack, each
        // followed immediately by a new request.
        run_abort("abort", 32'h3000_0060, 1'b0);
        run_txn("after_abort", CFG_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_abort("abort_ack", 32'h3000_0064, 1'b1);
        run_txn("after_abort_ack", CFG_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);

        // Randomized mix.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 5);
            adr  = $urandom;
            if (adr == CFG_ADDR || adr == STATUS_ADDR) adr = adr ^ 32'h1;
            case (kind)
                0: run_txn("rnd_rd_cfg", CFG_ADDR, 1'b0, 32'h0, 4'($urandom), 0, 32'h0);
                1: run_txn("rnd_wr_cfg", CFG_ADDR, 1'b1, $urandom, 4'($urandom), 0, 32'h0);
                2: run_txn("rnd_status", STATUS_ADDR, $urandom_range(0, 3) == 0, $urandom,
                           4'hF, 0, 32'h0);
                default: run_txn("rnd_fwd", adr, 1'($urandom), $urandom, 4'($urandom),
                                 $urandom_range(1, TIMEOUT + 3), $urandom);
            endcase
        end

        // Reset in the middle of a forward.
        run_txn("pre_rst_cfg", CFG_ADDR, 1'b1, 32'h0000_0001, 4'h1, 0, 32'h0);
        drive_req(32'h3000_0070, 1'b0, 32'h0, 4'hF);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst_fwd_busy", {31'b0, bus.fab_stb_o}, 32'd1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("rst_async_stb", {31'b0, bus.fab_stb_o}, 32'd0);
        check("rst_async_cyc", {31'b0, bus.fab_cyc_o}, 32'd0);
        check("rst_async_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        drive_idle();
        @(negedge wb_clk_i);
        check_all_zero("rst_mid");
        m_cfg  = 4'd0;
        m_flag = 1'b0;
        m_cnt  = 8'd0;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("rst_release_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        run_txn("post_rst_cfg", CFG_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_txn("post_rst_status", STATUS_ADDR, 1'b0, 32'h0, 4'hF, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
